// File: rtl/common.sv
// Shared types and widths for the memory-stage data memory path.
package common;

    localparam int unsigned REGISTER_WIDTH    = 32;
    localparam int unsigned MEM_ADDRESS_WIDTH = 32;
    localparam int unsigned BYTE_WIDTH        = 8;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } FUNC3_LOAD;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } STypeFunct3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } DmemState;

    typedef struct packed {
        logic                         write;
        logic [2:0]                   funct3;
        logic [MEM_ADDRESS_WIDTH-1:0] address;
        logic [REGISTER_WIDTH-1:0]    wdata;
    } dmem_request_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// DMEM_ALIGN_CHECK_EN: flag misaligned half/word accesses instead of aligning them down.
module dmem_lane_align
    import common::*;
(
    input  logic                      write,
    input  logic [2:0]                funct3,
    input  logic [1:0]                addr_lo,
    input  logic [REGISTER_WIDTH-1:0] wdata,
    input  logic [REGISTER_WIDTH-1:0] rword,
    output logic [3:0]                byte_en,
    output logic [REGISTER_WIDTH-1:0] wdata_lane,
    output logic [REGISTER_WIDTH-1:0] rdata_ext,
    output logic                      funct3_err,
    output logic                      misalign_err
);

    logic [1:0]                off;
    logic [REGISTER_WIDTH-1:0] shifted;

    always_comb begin
        byte_en      = '0;
        wdata_lane   = '0;
        rdata_ext    = '0;
        funct3_err   = 1'b0;
        misalign_err = 1'b0;

        // Halfword and word accesses are aligned down to their natural boundary
        case (funct3[1:0])
            2'b00:   off = addr_lo;
            2'b01:   off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        shifted = rword >> {off, 3'b000};

        if (write) begin
            case (funct3)
                SB: begin
                    byte_en    = 4'b0001 << off;
                    wdata_lane = {4{wdata[7:0]}};
                end
                SH: begin
                    byte_en    = 4'b0011 << off;
                    wdata_lane = {2{wdata[15:0]}};
                end
                SW: begin
                    byte_en    = 4'b1111;
                    wdata_lane = wdata;
                end
                default: funct3_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                LBU:     rdata_ext = {24'd0, shifted[7:0]};
                LH:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                LHU:     rdata_ext = {16'd0, shifted[15:0]};
                LW:      rdata_ext = shifted;
                default: funct3_err = 1'b1;
            endcase
        end

`ifdef DMEM_ALIGN_CHECK_EN
        misalign_err = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
        misalign_err = 1'b0;
`endif
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-port data memory answering load/store requests over valid/ready channels.
// Alignment checking is selected by DMEM_ALIGN_CHECK_EN (see dmem_lane_align).
module data_memory_responder
    import common::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [2:0]                   req_funct3,
    input  logic [MEM_ADDRESS_WIDTH-1:0] req_address,
    input  logic [REGISTER_WIDTH-1:0]    req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [REGISTER_WIDTH-1:0]    rsp_rdata,
    output logic                         rsp_error
);

    localparam int unsigned IDX_W   = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int unsigned WIDX_W  = MEM_ADDRESS_WIDTH - 2;
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

    DmemState                  state_q, state_d;
    dmem_request_t             req_q, req_d, cur_req;
    logic [3:0]                wait_cnt_q, wait_cnt_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [REGISTER_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_error_q, rsp_error_d;

    logic                      accept, commit, range_err, err;
    logic [IDX_W-1:0]          word_idx;
    logic [REGISTER_WIDTH-1:0] rword, wdata_lane, rdata_ext;
    logic [3:0]                byte_en;
    logic                      funct3_err, misalign_err;

    logic [REGISTER_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];

    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // With zero wait states the access commits on the accept edge, so use the live request
    assign cur_req   = (state_q == IDLE) ?
                       dmem_request_t'({req_write, req_funct3, req_address, req_wdata}) : req_q;
    assign range_err = cur_req.address[MEM_ADDRESS_WIDTH-1:2] >= WIDX_W'(MEM_DEPTH_WORDS);
    assign word_idx  = cur_req.address[IDX_W+1:2];
    assign rword     = mem_q[word_idx];
    assign err       = range_err || funct3_err || misalign_err;

    dmem_lane_align u_lane (
        .write        (cur_req.write),
        .funct3       (cur_req.funct3),
        .addr_lo      (cur_req.address[1:0]),
        .wdata        (cur_req.wdata),
        .rword        (rword),
        .byte_en      (byte_en),
        .wdata_lane   (wdata_lane),
        .rdata_ext    (rdata_ext),
        .funct3_err   (funct3_err),
        .misalign_err (misalign_err)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d = cur_req;
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        wait_cnt_d = 4'd0;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == WS_LAST) begin
                    commit  = 1'b1;
                    state_d = RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = err;
            rsp_rdata_d = (err || cur_req.write) ? '0 : rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Storage is not reset; a store held in reset never commits
    always_ff @(posedge clk) begin
        if (rst_n && commit && cur_req.write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_lane[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized scoreboard bench for data_memory_responder against a byte-level memory model.
module tb_data_memory_responder;

    localparam int unsigned WS    = 1;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    data_memory_responder #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ncyc     = 0;
    bit          hs_q     = 1'b0;
    bit          seen     = 1'b0;
    bit          hold     = 1'b0;
    bit          rand_bp  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    // Reference: access size, aligned-down byte offset, little-endian byte copy
    function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          sz;
        int          off;
        logic [31:0] widx, word, v, mask;
        rd = '0;
        er = 1'b0;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: sz = w ? 0 : 1;
            3'd5: sz = w ? 0 : 2;
            default: sz = 0;
        endcase
        if (sz == 0) er = 1'b1;
        widx = a >> 2;
        if (widx >= DEPTH) er = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz != 0 && (a % sz) != 0) er = 1'b1;
`endif
        if (er) return;
        off  = ((a % 4) / sz) * sz;
        word = mdl[widx];
        if (w) begin
            for (int i = 0; i < sz; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
            mdl[widx] = word;
        end else begin
            v    = word >> (8*off);
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
            v    = v & mask;
            if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
            rd = v;
        end
    endfunction

    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   t = 0;
        model(w, f3, a, wd, e.rdata, e.err);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            e.acc = ncyc;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        hs_q <= rst_n && rsp_valid && rsp_ready;
    end

    always @(negedge clk) begin
        rsp_ready = hold ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: checks each response against the head of the scoreboard
    always @(negedge clk) begin
        exp_t cur;
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (hs_q) begin
                if (sb.size() > 0) cur = sb.pop_front();
                seen = 1'b0;
                chk("valid_after_hs", 32'(rsp_valid), 32'd0);
                chk("ready_after_hs", 32'(req_ready), 32'd1);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0d expected no response", rsp_rdata, rsp_error);
                end else begin
                    cur = sb[0];
                    if (!seen) chk("latency", 32'(ncyc - cur.acc), 32'(WS + 1));
                    seen = 1'b1;
                    chk("rdata", rsp_rdata, cur.rdata);
                    chk("error", 32'(rsp_error), 32'(cur.err));
                    chk("ready_busy", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [2:0] ld_ok [5];
        logic [2:0] st_ok [3];
        logic [31:0] a;
        logic [2:0]  f3;
        bit          w;
        int          t;
        ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_ok = '{3'd0, 3'd1, 3'd2};
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_address = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) issue(1'b1, 3'd2, 32'(i * 4), $urandom);

        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b1, 3'd0, 32'h13, 32'h80);
        issue(1'b0, 3'd0, 32'h13, 32'h0);
        issue(1'b0, 3'd4, 32'h13, 32'h0);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b1, 3'd1, 32'h12, 32'h1234);
        issue(1'b0, 3'd5, 32'h12, 32'h0);
        issue(1'b0, 3'd1, 32'h10, 32'h0);
        issue(1'b0, 3'd2, 32'h11, 32'h0);
        issue(1'b1, 3'd2, 32'h12, 32'h77777777);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0);
        issue(1'b0, 3'd3, 32'h10, 32'h0);
        issue(1'b1, 3'd5, 32'h10, 32'hFFFF_FFFF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        drain();

        // Back-pressure: response must hold while rsp_ready is low
        hold = 1'b1;
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        hold = 1'b0;
        drain();

        // Reset during WAIT drops the store
        issue(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
        drain();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_address = 32'h20; req_wdata = 32'h55;
        chk("pre_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_req_ready", 32'(req_ready), 32'd0);
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        drain();

        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = w ? st_ok[$urandom_range(0, 2)] : ld_ok[$urandom_range(0, 4)];
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            issue(w, f3, a, $urandom);
        end
        rand_bp = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
